// File: rtl/coder_lane_arbiter.sv
// coder_lane_arbiter
//   Round-robin merge of N_LANES per-lane byte streams into one indexed
//   output stream (idx/byte/last). The output is a one-entry register stage.
//   Each lane is retired once it delivers its last byte. The global last
//   marks the final byte of the final lane to finish. After that beat is
//   consumed the arbiter pulses done and rearms for the next stream.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
//   both high. A valid source holds its data stable until that edge. in_ready
//   is one-hot or zero and is combinational. out_valid/out_bits_* come
//   straight from registers.
//
// Ports:
//   clk, rst_n     coder clock, asynchronous active-low reset
//   in_valid       per-lane byte valid            [N_LANES]
//   in_ready       per-lane accept, one-hot/zero  [N_LANES]
//   in_bits_byte   lane i byte at [8i+7:8i]       [8*N_LANES]
//   in_bits_last   lane i final byte              [N_LANES]
//   out_valid      merged stream valid
//   out_ready      sink ready
//   out_bits_idx   source lane of beat, zero-extended to 8 bits
//   out_bits_byte  beat byte
//   out_bits_last  final beat of the whole stream
//   lane_done      lane i has delivered its last byte [N_LANES]
//   done           one-cycle pulse after the final beat handshake
//   beat_cnt       output beats transferred since reset [CNT_W]
//   dbg_state      FSM state (0 = RUN, 1 = FLUSH)
module coder_lane_arbiter #(
  parameter int N_LANES = 8,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_LANES-1:0]     in_valid,
  output logic [N_LANES-1:0]     in_ready,
  input  logic [8*N_LANES-1:0]   in_bits_byte,
  input  logic [N_LANES-1:0]     in_bits_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_bits_idx,
  output logic [7:0]             out_bits_byte,
  output logic                   out_bits_last,
  output logic [N_LANES-1:0]     lane_done,
  output logic                   done,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic                   dbg_state
);

  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LW-1:0]       r_ptr;
  logic                r_out_valid;
  logic [7:0]          r_out_idx;
  logic [7:0]          r_out_byte;
  logic                r_out_last;
  logic [N_LANES-1:0]  r_lane_done;
  logic                r_done;
  logic [CNT_W-1:0]    r_beat_cnt;

  logic                w_slot_free;
  logic [N_LANES-1:0]  w_elig;
  logic                w_gnt_found;
  logic [LW-1:0]       w_gnt_idx;
  logic [LW:0]         w_scan;
  logic [N_LANES-1:0]  w_in_ready;
  logic                w_accept;
  logic                w_gnt_last;
  logic [7:0]          w_gnt_byte;
  logic                w_others_done;
  logic                w_out_hs;
  logic                w_final_hs;
  logic [LW-1:0]       w_ptr_nxt;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_elig      = in_valid & ~r_lane_done & {N_LANES{r_state == ST_RUN}};

  // Scan ptr, ptr+1, ... (mod N_LANES) and take the first eligible lane.
  // w_scan is one bit wider than the pointer so ptr+k cannot overflow before
  // the wrap subtraction.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_scan      = '0;
    for (int k = 0; k < N_LANES; k++) begin
      w_scan = {1'b0, r_ptr} + (LW+1)'(k);
      if (w_scan >= (LW+1)'(N_LANES)) w_scan = w_scan - (LW+1)'(N_LANES);
      if (!w_gnt_found && w_elig[w_scan[LW-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_scan[LW-1:0];
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    if (w_gnt_found && w_slot_free) w_in_ready[w_gnt_idx] = 1'b1;
  end

  assign w_accept   = w_gnt_found && w_slot_free;
  assign w_gnt_last = in_bits_last[w_gnt_idx];
  assign w_gnt_byte = in_bits_byte[8*int'(w_gnt_idx) +: 8];
  // The granted lane is not done yet, so OR-ing its one-hot in tests
  // "every other lane is already done".
  assign w_others_done = &(r_lane_done | w_in_ready);
  assign w_out_hs      = r_out_valid && out_ready;
  assign w_final_hs    = w_out_hs && r_out_last;
  assign w_ptr_nxt     = (w_gnt_idx == LW'(N_LANES-1)) ? '0 : w_gnt_idx + LW'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_accept && w_gnt_last && w_others_done) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_final_hs) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_byte  <= '0;
      r_out_last  <= 1'b0;
      r_lane_done <= '0;
      r_done      <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_final_hs;
      if (w_out_hs) r_beat_cnt <= r_beat_cnt + CNT_W'(1);

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= 8'(w_gnt_idx);
        r_out_byte  <= w_gnt_byte;
        r_ptr       <= w_ptr_nxt;
        r_out_last  <= w_gnt_last && w_others_done;
        if (w_gnt_last) r_lane_done <= r_lane_done | w_in_ready;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      // Only reachable in FLUSH, where no accept can happen, so this never
      // collides with the accept branch above.
      if (w_final_hs) begin
        r_lane_done <= '0;
        r_ptr       <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_out_valid;
  assign out_bits_idx  = r_out_idx;
  assign out_bits_byte = r_out_byte;
  assign out_bits_last = r_out_last;
  assign lane_done     = r_lane_done;
  assign done          = r_done;
  assign beat_cnt      = r_beat_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_coder_lane_arbiter.sv
module tb_coder_lane_arbiter;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [8*N-1:0] in_bits_byte;
  logic [N-1:0]  in_bits_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_bits_idx;
  logic [7:0]    out_bits_byte;
  logic          out_bits_last;
  logic [N-1:0]  lane_done;
  logic          done;
  logic [31:0]   beat_cnt;
  logic          dbg_state;

  coder_lane_arbiter #(.N_LANES(N), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits_byte(in_bits_byte), .in_bits_last(in_bits_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits_idx(out_bits_idx), .out_bits_byte(out_bits_byte),
    .out_bits_last(out_bits_last), .lane_done(lane_done),
    .done(done), .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  int tb_beats = 0;
  int done_seen = 0;
  int cyc = 0;
  int hs_this = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int rdy_mode = 0;          // 0: always ready, 1: random, 2: never ready
  int m_ptr = 0;
  logic [N-1:0] m_done = '0;
  int lens [N];
  int pos [N];
  logic [7:0] bytes [N][8];
  logic [N-1:0] hold = '0;
  logic [16:0] exp_q [$];    // {last, idx, byte}
  logic [7:0] first_idx;
  logic [7:0] last_idx_seen;

  // ---------------- reference model ----------------
  // Round-robin over lanes that still have bytes to send: every lane presents
  // its next byte continuously, so the merged order does not depend on sink
  // backpressure. Global last is the byte that makes all N lanes finished.
  task automatic build_expected();
    int rem [N];
    int p;
    int fin;
    bit found;
    for (int i = 0; i < N; i++) rem[i] = lens[i] - pos[i];
    p = m_ptr;
    fin = $countones(m_done);
    do begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int l;
        l = (p + k) % N;
        if (!found && rem[l] > 0) begin
          logic lst;
          found = 1;
          rem[l]--;
          lst = 1'b0;
          if (rem[l] == 0) begin
            fin++;
            lst = (fin == N);
          end
          exp_q.push_back({lst, 8'(l), bytes[l][lens[l] - rem[l] - 1]});
          p = (l + 1) % N;
          if (lst) p = 0;
        end
      end
    end while (found);
    m_ptr = p;
  endtask

  task automatic load_stream(input int l0, input int l1, input int l2, input int l3,
                             input int l4, input int l5, input int l6, input int l7);
    int ls [N];
    ls = '{l0, l1, l2, l3, l4, l5, l6, l7};
    for (int i = 0; i < N; i++) begin
      lens[i] = ls[i];
      pos[i] = 0;
      for (int j = 0; j < 8; j++) bytes[i][j] = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_lanes();
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [8*N-1:0] b;
    v = '0; l = '0; b = '0;
    for (int i = 0; i < N; i++) begin
      if (pos[i] < lens[i]) begin
        v[i] = 1'b1;
        b[8*i +: 8] = bytes[i][pos[i]];
        l[i] = (pos[i] == lens[i] - 1);
      end else if (hold[i]) begin
        v[i] = 1'b1;
        b[8*i +: 8] = 8'hEE;
      end
    end
    in_valid = v;
    in_bits_byte = b;
    in_bits_last = l;
  endtask

  // One clock cycle: drive at negedge, sample handshakes just before the
  // edge, update the model after the edge and check registered outputs.
  task automatic step();
    logic [N-1:0] acc;
    logic hs, s_last, bad;
    logic [7:0] s_idx, s_byte;
    logic [16:0] e;
    @(negedge clk);
    drive_lanes();
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    #1;
    acc = in_valid & in_ready;
    hs = out_valid & out_ready;
    s_idx = out_bits_idx; s_byte = out_bits_byte; s_last = out_bits_last;
    bad = !$onehot0(in_ready) || ((in_ready & ~in_valid) != 0) ||
          ((in_ready & m_done) != 0) || (out_valid && !out_ready && (in_ready != 0));
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL in_ready_legal cyc=%0d in_ready=%b in_valid=%b model_done=%b out_valid=%b out_ready=%b",
               cyc, in_ready, in_valid, m_done, out_valid, out_ready);
    end
    if (hs) begin
      tb_beats++;
      if (hs_this == 0) begin first_cyc = cyc; first_idx = s_idx; end
      last_cyc = cyc;
      hs_this++;
      if (s_last) last_idx_seen = s_idx;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected cyc=%0d got last=%0b idx=%0d byte=%02h, none expected",
                 cyc, s_last, s_idx, s_byte);
      end else begin
        e = exp_q.pop_front();
        if ({s_last, s_idx, s_byte} !== e) begin
          errors++;
          $display("FAIL beat cyc=%0d got last=%0b idx=%0d byte=%02h expected last=%0b idx=%0d byte=%02h",
                   cyc, s_last, s_idx, s_byte, e[16], e[15:8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (pos[i] < lens[i]) begin
          if (pos[i] == lens[i] - 1) m_done[i] = 1'b1;
          pos[i]++;
        end else begin
          checks++;
          errors++;
          $display("FAIL idle_accept cyc=%0d lane=%0d accepted with no byte pending", cyc, i);
        end
      end
    end
    if (hs && s_last) m_done = '0;
    checks++;
    if (done !== (hs && s_last)) begin
      errors++;
      $display("FAIL done cyc=%0d got %b expected %b", cyc, done, hs && s_last);
    end
    checks++;
    if (beat_cnt !== 32'(tb_beats)) begin
      errors++;
      $display("FAIL beat_cnt cyc=%0d got %0d expected %0d", cyc, beat_cnt, tb_beats);
    end
    checks++;
    if (lane_done !== m_done) begin
      errors++;
      $display("FAIL lane_done cyc=%0d got %b expected %b", cyc, lane_done, m_done);
    end
    if (done === 1'b1) done_seen++;
  endtask

  task automatic run_until_done(input int max_cyc);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (done_seen == start) begin
      errors++;
      $display("FAIL stream_timeout no done within %0d cycles", max_cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats got %0d unconsumed expected 0", exp_q.size());
    end
  endtask

  // Asynchronous reset asserted wherever the caller is in the cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin lens[i] = 0; pos[i] = 0; end
    hold = '0;
    exp_q.delete();
    m_done = '0;
    m_ptr = 0;
    tb_beats = 0;
    drive_lanes();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bits_last !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b last=%b done=%b expected 0 0 0", out_valid, out_bits_last, done);
    end
    checks++;
    if (out_bits_idx !== 8'h00 || out_bits_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got idx=%0d byte=%02h expected 0 00", out_bits_idx, out_bits_byte);
    end
    checks++;
    if (lane_done !== '0 || beat_cnt !== 32'd0 || in_ready !== '0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got lane_done=%b beat_cnt=%0d in_ready=%b state=%b expected 0",
               lane_done, beat_cnt, in_ready, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0; in_bits_byte = '0; in_bits_last = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin lens[i] = 0; pos[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Put a beat in the output register, then reset in the middle of a cycle.
    load_stream(0, 0, 0, 2, 0, 0, 0, 0);
    build_expected();
    rdy_mode = 2;
    step();
    step();
    #2;
    do_reset();
  endtask

  task automatic test_full_stream();
    int start;
    do_reset();
    load_stream(2, 2, 2, 2, 2, 2, 2, 2);
    build_expected();
    rdy_mode = 0;
    hs_this = 0;
    start = done_seen;
    run_until_done(60);
    checks++;
    if (hs_this != 16 || last_cyc - first_cyc != 15) begin
      errors++;
      $display("FAIL full_throughput got beats=%0d span=%0d expected 16 beats over 15 cycles",
               hs_this, last_cyc - first_cyc);
    end
    checks++;
    if (last_idx_seen !== 8'd7) begin
      errors++;
      $display("FAIL full_last_idx got %0d expected 7", last_idx_seen);
    end
    step();
    step();
    checks++;
    if (beat_cnt !== 32'd16 || done_seen - start != 1) begin
      errors++;
      $display("FAIL full_summary got beat_cnt=%0d done_pulses=%0d expected 16 and 1",
               beat_cnt, done_seen - start);
    end
  endtask

  task automatic test_two_lanes();
    do_reset();
    load_stream(0, 0, 0, 3, 0, 3, 0, 0);
    build_expected();
    rdy_mode = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      checks++;
      if ((in_ready & ~8'b0010_1000) != 0) begin
        errors++;
        $display("FAIL two_lane_ready cyc=%0d got in_ready=%b expected only lanes 3/5", cyc, in_ready);
      end
    end
    checks++;
    if (exp_q.size() != 0 || lane_done !== 8'b0010_1000) begin
      errors++;
      $display("FAIL two_lane_end got pending=%0d lane_done=%b expected 0 and 00101000",
               exp_q.size(), lane_done);
    end
  endtask

  task automatic test_single_byte_lane();
    do_reset();
    load_stream($urandom_range(2, 4), $urandom_range(2, 4), 1, $urandom_range(2, 4),
                $urandom_range(2, 4), $urandom_range(2, 4), $urandom_range(2, 4),
                $urandom_range(2, 4));
    build_expected();
    hold = 8'b0000_0100;
    rdy_mode = 1;
    run_until_done(200);
    checks++;
    if (last_idx_seen === 8'd2) begin
      errors++;
      $display("FAIL lane2_last got stream last from lane %0d expected another lane", last_idx_seen);
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    load_stream(0, 0, 0, 0, 2, 0, 0, 0);
    bytes[4][0] = 8'hA5;
    bytes[4][1] = 8'h3C;
    build_expected();
    rdy_mode = 2;
    n = 0;
    while (out_valid !== 1'b1 && n < 5) begin step(); n++; end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_bits_idx !== 8'd4 || out_bits_byte !== 8'hA5 ||
          out_bits_last !== 1'b0 || in_ready !== '0 || beat_cnt !== 32'd0) begin
        errors++;
        $display("FAIL stall cyc=%0d got valid=%b idx=%0d byte=%02h last=%b in_ready=%b beat_cnt=%0d expected 1 4 a5 0 0 0",
                 cyc, out_valid, out_bits_idx, out_bits_byte, out_bits_last, in_ready, beat_cnt);
      end
    end
    rdy_mode = 0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_bits_idx !== 8'd4 || out_bits_byte !== 8'h3C || beat_cnt !== 32'd1) begin
      errors++;
      $display("FAIL stall_release got valid=%b idx=%0d byte=%02h beat_cnt=%0d expected 1 4 3c 1",
               out_valid, out_bits_idx, out_bits_byte, beat_cnt);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_stream();
    int n;
    int start;
    do_reset();
    load_stream(2, 2, 2, 2, 2, 2, 2, 2);
    build_expected();
    rdy_mode = 1;
    n = 0;
    while (tb_beats < 5 && n < 40) begin step(); n++; end
    checks++;
    if (tb_beats < 5) begin
      errors++;
      $display("FAIL mid_progress got %0d beats expected 5", tb_beats);
    end
    #2;
    do_reset();
    load_stream(2, 2, 2, 2, 2, 2, 2, 2);
    build_expected();
    hs_this = 0;
    start = done_seen;
    run_until_done(200);
    step();
    checks++;
    if (first_idx !== 8'd0 || beat_cnt !== 32'd16 || done_seen - start != 1) begin
      errors++;
      $display("FAIL mid_restart got first_idx=%0d beat_cnt=%0d done_pulses=%0d expected 0 16 1",
               first_idx, beat_cnt, done_seen - start);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy_mode = 1;
    for (int s = 0; s < 3; s++) begin
      load_stream($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                  $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                  $urandom_range(1, 4), $urandom_range(1, 4));
      build_expected();
      run_until_done(300);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_two_lanes();
    test_single_byte_lane();
    test_backpressure();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
